// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory access type codes, EX/MEM buffer states
// and the control-field layout of one EX/MEM entry.
package pipe_pkg;

  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } ex_mem_state_t;

  // Address/data/PC are XLEN-wide and live beside this struct in the stage.
  typedef struct packed {
    logic [4:0] rd;
    logic [1:0] store_type;
    logic [2:0] load_type;
    logic       mem_read;
    logic       mem_write;
    logic       memtoreg;
    logic       reg_write;
    logic       misalign;
  } ex_mem_ctrl_t;

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment check for a load/store effective address.
// Undefined type codes are reported as misaligned.
module mem_align_check
  import pipe_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] store_type,
  input  logic [2:0] load_type,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       misalign
);

  logic st_bad;
  logic ld_bad;

  always_comb begin
    st_bad = 1'b0;
    case (store_type)
      ST_SB:   st_bad = 1'b0;
      ST_SH:   st_bad = addr[0];
      ST_SW:   st_bad = |addr;
      default: st_bad = 1'b1;
    endcase

    ld_bad = 1'b0;
    case (load_type)
      LD_LB, LD_LBU: ld_bad = 1'b0;
      LD_LH, LD_LHU: ld_bad = addr[0];
      LD_LW:         ld_bad = |addr;
      default:       ld_bad = 1'b1;
    endcase

    misalign = (mem_write & st_bad) | (mem_read & ld_bad);
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: 2-entry skid buffer with valid/ready on both sides,
// per-entry misalignment flag and gated memory enables toward data memory.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_alu_result,
  input  logic [XLEN-1:0]        in_rs2,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [4:0]             in_rd,
  input  logic [1:0]             in_store_type,
  input  logic [2:0]             in_load_type,
  input  logic                   in_mem_read,
  input  logic                   in_mem_write,
  input  logic                   in_memtoreg,
  input  logic                   in_reg_write,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        alu_result,
  output logic [XLEN-1:0]        rs2,
  output logic [XLEN-1:0]        pc,
  output logic [4:0]             rd,
  output logic [1:0]             store_type,
  output logic [2:0]             load_type,
  output logic                   memtoreg,
  output logic                   reg_write,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   misalign_trap,
  output logic [XLEN-1:0]        trap_addr,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  ex_mem_state_t   state;
  ex_mem_ctrl_t    head_c, skid_c, in_c;
  logic [XLEN-1:0] head_alu, head_rs2, head_pc;
  logic [XLEN-1:0] skid_alu, skid_rs2, skid_pc;
  logic            in_misalign;
  logic            accept;
  logic            pop;

  mem_align_check u_align (
    .addr       (in_alu_result[1:0]),
    .store_type (in_store_type),
    .load_type  (in_load_type),
    .mem_read   (in_mem_read),
    .mem_write  (in_mem_write),
    .misalign   (in_misalign)
  );

  always_comb begin
    in_c            = '0;
    in_c.rd         = in_rd;
    in_c.store_type = in_store_type;
    in_c.load_type  = in_load_type;
    in_c.mem_read   = in_mem_read;
    in_c.mem_write  = in_mem_write;
    in_c.memtoreg   = in_memtoreg;
    in_c.reg_write  = in_reg_write;
    in_c.misalign   = in_misalign;
  end

  assign out_valid = (state != S_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_EMPTY;
      in_ready     <= 1'b1;
      head_c       <= '0;
      skid_c       <= '0;
      head_alu     <= '0;
      head_rs2     <= '0;
      head_pc      <= '0;
      skid_alu     <= '0;
      skid_rs2     <= '0;
      skid_pc      <= '0;
      stall_cycles <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);

      if (flush) begin
        state    <= S_EMPTY;
        in_ready <= 1'b1;
      end else begin
        case (state)
          S_EMPTY: begin
            if (accept) begin
              head_c   <= in_c;
              head_alu <= in_alu_result;
              head_rs2 <= in_rs2;
              head_pc  <= in_pc;
              state    <= S_ONE;
            end
          end
          S_ONE: begin
            if (accept && pop) begin
              head_c   <= in_c;
              head_alu <= in_alu_result;
              head_rs2 <= in_rs2;
              head_pc  <= in_pc;
            end else if (accept) begin
              skid_c   <= in_c;
              skid_alu <= in_alu_result;
              skid_rs2 <= in_rs2;
              skid_pc  <= in_pc;
              state    <= S_TWO;
              in_ready <= 1'b0;
            end else if (pop) begin
              state    <= S_EMPTY;
            end
          end
          S_TWO: begin
            if (pop) begin
              head_c   <= skid_c;
              head_alu <= skid_alu;
              head_rs2 <= skid_rs2;
              head_pc  <= skid_pc;
              state    <= S_ONE;
              in_ready <= 1'b1;
            end
          end
          default: begin
            state    <= S_EMPTY;
            in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  // rst_n gates mem_write so an entry still held during the reset cycle never writes.
  always_comb begin
    alu_result    = '0;
    rs2           = '0;
    pc            = '0;
    rd            = '0;
    store_type    = '0;
    load_type     = '0;
    memtoreg      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    misalign_trap = 1'b0;
    trap_addr     = '0;
    if (out_valid) begin
      alu_result    = head_alu;
      rs2           = head_rs2;
      pc            = head_pc;
      rd            = head_c.rd;
      store_type    = head_c.store_type;
      load_type     = head_c.load_type;
      memtoreg      = head_c.memtoreg;
      reg_write     = head_c.reg_write & ~head_c.misalign;
      mem_read      = head_c.mem_read & ~head_c.misalign;
      mem_write     = out_ready & head_c.mem_write & ~head_c.misalign & ~flush & rst_n;
      misalign_trap = head_c.misalign;
      trap_addr     = head_c.misalign ? head_alu : '0;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with a queue scoreboard of held entries,
// compared against the DUT every cycle on the falling clock edge.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result, in_rs2, in_pc;
  logic [4:0]  in_rd;
  logic [1:0]  in_store_type;
  logic [2:0]  in_load_type;
  logic        in_mem_read, in_mem_write, in_memtoreg, in_reg_write;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result, rs2, pc, trap_addr;
  logic [4:0]  rd;
  logic [1:0]  store_type;
  logic [2:0]  load_type;
  logic        memtoreg, reg_write, mem_read, mem_write, misalign_trap;
  logic [3:0]  stall_cycles;

  ex_mem_stage #(.XLEN(32), .STALL_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_rs2(in_rs2), .in_pc(in_pc), .in_rd(in_rd),
    .in_store_type(in_store_type), .in_load_type(in_load_type),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_memtoreg(in_memtoreg), .in_reg_write(in_reg_write), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .rs2(rs2), .pc(pc), .rd(rd), .store_type(store_type), .load_type(load_type),
    .memtoreg(memtoreg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .misalign_trap(misalign_trap), .trap_addr(trap_addr),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, rs2, pc;
    logic [4:0]  rd;
    logic [1:0]  st;
    logic [2:0]  lt;
    logic        mr, mw, m2r, rw, mis;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  sc_model = 4'h0;
  bit          rst_done = 1'b0;

  function automatic logic exp_misalign(input logic [1:0] a, input logic [1:0] st,
                                        input logic [2:0] lt, input logic mr, input logic mw);
    logic s_bad, l_bad;
    s_bad = (st == 2'b11) || (st == 2'b01 && a[0]) || (st == 2'b10 && a != 2'b00);
    l_bad = (lt > 3'd4) || ((lt == 3'd1 || lt == 3'd4) && a[0]) || (lt == 3'd2 && a != 2'b00);
    return (mw && s_bad) || (mr && l_bad);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: compare on the falling edge, advance the model, then step past posedge.
  task automatic cycle();
    exp_t h, e;
    bit   acc, pp;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      if (rst_done) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
      end
      q.delete();
      sc_model = 4'h0;
      rst_done = 1'b1;
    end else begin
      rst_done = 1'b0;
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("stall_cycles", 32'(stall_cycles), 32'(sc_model));
      if (q.size() != 0) begin
        h = q[0];
        chk("alu_result", alu_result, h.alu);
        chk("rs2", rs2, h.rs2);
        chk("pc", pc, h.pc);
        chk("rd", 32'(rd), 32'(h.rd));
        chk("store_type", 32'(store_type), 32'(h.st));
        chk("load_type", 32'(load_type), 32'(h.lt));
        chk("memtoreg", 32'(memtoreg), 32'(h.m2r));
        chk("reg_write", 32'(reg_write), 32'(h.rw && !h.mis));
        chk("mem_read", 32'(mem_read), 32'(h.mr && !h.mis));
        chk("mem_write", 32'(mem_write), 32'(h.mw && !h.mis && out_ready && !flush));
        chk("misalign_trap", 32'(misalign_trap), 32'(h.mis));
        chk("trap_addr", trap_addr, h.mis ? h.alu : 32'd0);
      end else begin
        chk("idle_alu_result", alu_result, 32'd0);
        chk("idle_mem_write", 32'(mem_write), 32'd0);
        chk("idle_mem_read", 32'(mem_read), 32'd0);
        chk("idle_trap", 32'(misalign_trap), 32'd0);
        chk("idle_trap_addr", trap_addr, 32'd0);
      end
      if (q.size() != 0 && !out_ready && sc_model != 4'hF) sc_model = sc_model + 4'h1;
      acc = in_valid && (q.size() < 2);
      pp  = (q.size() != 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (pp) void'(q.pop_front());
        if (acc) begin
          e.alu = in_alu_result; e.rs2 = in_rs2; e.pc = in_pc; e.rd = in_rd;
          e.st = in_store_type; e.lt = in_load_type; e.mr = in_mem_read;
          e.mw = in_mem_write; e.m2r = in_memtoreg; e.rw = in_reg_write;
          e.mis = exp_misalign(in_alu_result[1:0], in_store_type, in_load_type,
                               in_mem_read, in_mem_write);
          q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st);
    in_valid = 1'b1; in_alu_result = a; in_rs2 = d; in_pc = 32'h1000 + a; in_rd = 5'd0;
    in_store_type = st; in_load_type = 3'b000; in_mem_read = 1'b0; in_mem_write = 1'b1;
    in_memtoreg = 1'b0; in_reg_write = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] r, input logic [2:0] lt);
    in_valid = 1'b1; in_alu_result = a; in_rs2 = 32'h0; in_pc = 32'h2000 + a; in_rd = r;
    in_store_type = 2'b00; in_load_type = lt; in_mem_read = 1'b1; in_mem_write = 1'b0;
    in_memtoreg = 1'b1; in_reg_write = 1'b1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    store(32'h4, 32'h11223344, 2'b10);
    @(posedge clk); #1;
    rst_done = 1'b1;

    // Reset held two cycles with a valid beat presented
    cycle(); cycle();
    rst_n = 1'b1; in_valid = 1'b0;
    cycle();

    // Back-to-back SW then LW with the consumer always ready
    store(32'h4, 32'hAABBCCDD, 2'b10);
    cycle();
    load(32'h4, 5'd5, 3'b010);
    cycle();
    in_valid = 1'b0;
    cycle(); cycle();

    // Backpressure: two beats fill the buffer, a third is held off
    reset_dut();
    out_ready = 1'b0;
    load(32'h8, 5'd8, 3'b010);
    cycle();
    load(32'hC, 5'd9, 3'b010);
    cycle();
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    load(32'h10, 5'd10, 3'b010);
    cycle(); cycle(); cycle();
    chk("bp_in_ready_held", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    cycle(); cycle(); cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    chk("bp_in_ready_drained", 32'(in_ready), 32'd1);

    // Misaligned SH and LW pop normally but never reach memory
    store(32'h13, 32'h5555, 2'b01);
    cycle();
    load(32'h12, 5'd7, 3'b010);
    cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    // Undefined type codes and aligned halfword/byte variants
    store(32'h40, 32'h77, 2'b11);
    cycle();
    load(32'h42, 5'd3, 3'b100);
    cycle();
    load(32'h43, 5'd4, 3'b011);
    cycle();
    load(32'h44, 5'd6, 3'b110);
    cycle();
    in_valid = 1'b0;
    cycle(); cycle();

    // Flush with a store at the head of a full buffer and consumer ready
    out_ready = 1'b0;
    store(32'h20, 32'hDEAD0001, 2'b10);
    cycle();
    store(32'h24, 32'hDEAD0002, 2'b10);
    cycle();
    store(32'h28, 32'hDEAD0003, 2'b10);
    flush = 1'b1; out_ready = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cycle(); cycle();

    // Reset while a store sits at the head with the consumer ready
    store(32'h30, 32'hCAFE0000, 2'b10);
    cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // Stall counter saturation
    out_ready = 1'b0;
    load(32'h50, 5'd2, 3'b000);
    cycle();
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 20; i++) cycle();
    chk("stall_saturated", 32'(stall_cycles), 32'hF);
    out_ready = 1'b1;
    cycle(); cycle();
    chk("stall_kept", 32'(stall_cycles), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
EX/MEM pipeline stage sitting directly upstream of data_memory_unit.
- Captures execute-stage results: effective address, store data, load/store type, rd and control bits.
- Holds them in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Detects misaligned accesses and gates the memory enables so that each store reaches memory exactly once, and never when misaligned or flushed.

Parameters:
XLEN, 32, width of address/data/PC fields
STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  EX presents a valid beat
in_ready  out  1  stage can accept a beat (registered)
in_alu_result  in  XLEN  effective address / ALU result
in_rs2  in  XLEN  store data
in_pc  in  XLEN  instruction PC
in_rd  in  5  destination register
in_store_type  in  2  00=SB, 01=SH, 10=SW
in_load_type  in  3  000=LB, 001=LH, 010=LW, 011=LBU, 100=LHU
in_mem_read  in  1  load instruction
in_mem_write  in  1  store instruction
in_memtoreg  in  1  WB selects load result
in_reg_write  in  1  instruction writes rd
flush  in  1  kill all held beats (branch/trap redirect)
out_valid  out  1  head entry valid toward MEM
out_ready  in  1  MEM/WB consumer accepts head this cycle
alu_result, rs2, pc  out  XLEN  head entry fields
rd  out  5  head rd
store_type  out  2  head store_type
load_type  out  3  head load_type
memtoreg, reg_write  out  1  head control bits (reg_write forced 0 if misaligned)
mem_read  out  1  out_valid & head.mem_read & ~head.misalign
mem_write  out  1  out_valid & out_ready & head.mem_write & ~head.misalign & ~flush
misalign_trap  out  1  out_valid & head.misalign (held until head is consumed)
trap_addr  out  XLEN  head alu_result when misalign_trap is 1, else 0
stall_cycles  out  STALL_CNT_W  count of cycles with out_valid & ~out_ready, saturating

Behaviour:
- Reset (rst_n=0 at posedge): both entries invalid, state EMPTY, in_ready=1, out_valid=0, all data outputs 0, stall_cycles=0. Reset mid-transfer discards both entries; no mem_write is issued in the reset cycle or the following cycle.
- Storage: head register plus skid register. Output fields are driven from the head, zeroed when out_valid=0.
- Transfer rules: accept occurs when in_valid & in_ready; pop occurs when out_valid & out_ready.
- FSM states:
  - EMPTY: accept -> ONE, data goes to head.
  - ONE: accept & pop -> ONE, head replaced. Accept & ~pop -> TWO, data goes to skid. Pop & ~accept -> EMPTY.
  - TWO: in_ready=0. Pop -> ONE, skid moves to head. Otherwise hold.
- in_ready is registered: 1 in EMPTY and ONE, 0 in TWO. Latency is 1 cycle from accept to out_valid; no combinational path from in_* to out_*.
- Misalignment is computed at accept and stored per entry:
  - store: SH with addr[0]=1, SW with addr[1:0]!=0.
  - load: LH/LHU with addr[0]=1, LW with addr[1:0]!=0.
  - SB/LB/LBU never misalign.
  - Undefined type codes (store 11, load 101-111) are treated as misaligned.
- A misaligned head still pops normally on out_ready. It never asserts mem_read or mem_write.
- Flush at a posedge: next state EMPTY, both entries invalid. A beat accepted in the same cycle is discarded; flush has priority over accept and pop. mem_write is forced 0 in the flush cycle.
- Simultaneous in_valid/out_ready in TWO: only the pop occurs, input is not accepted.
- stall_cycles increments when out_valid & ~out_ready, and saturates at all-ones. Only reset clears it; flush does not.

Decomposition:
- Shared package pipe_pkg holds:
  - store type constants ST_SB/ST_SH/ST_SW
  - load type constants LD_LB/LD_LH/LD_LW/LD_LBU/LD_LHU
  - FSM state encoding S_EMPTY/S_ONE/S_TWO
  - the ex_mem entry field layout
- One combinational sub-module, mem_align_check, with inputs addr[1:0], store_type, load_type, mem_read and mem_write, and output misalign. It is reusable by the load/store units.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, mem_write=0, stall_cycles=0.
- Back-to-back flow with out_ready=1: SW addr 0x4 data 0xAABBCCDD, then LW 0x4 -> one cycle each. mem_write=1 exactly one cycle with alu_result=0x4, rs2=0xAABBCCDD; next cycle mem_read=1, memtoreg=1.
- Backpressure: out_ready=0, push 2 beats (addr 0x8, 0xC) -> state TWO, in_ready=0, third beat held by EX, stall_cycles increments each cycle. Release out_ready -> outputs appear in order 0x8 then 0xC, then in_ready=1.
- Misaligned: SH at 0x13, LW at 0x12 -> misalign_trap=1 with trap_addr=0x13 and then 0x12; mem_write=0, mem_read=0, reg_write=0.
- Flush in TWO with a store at head and out_ready=1 in the same cycle -> mem_write=0 that cycle; next cycle out_valid=0, state EMPTY.
- Saturation: STALL_CNT_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_cycles stops at 0xF.
